// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: instruction prefetch queue between a single-outstanding
// word fetch bus and the decode stage. Words are pushed into a small FIFO as
// they are acknowledged. The output side walks the FIFO halfword by halfword
// so that compressed (16-bit) instructions and word-straddling 32-bit
// instructions are delivered with their exact PC.
module rv_fetch_queue #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4,
  parameter int          EXT_C      = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_pc_select,
  input  logic [31:0]            i_pc_target,
  output logic [31:0]            o_addr,
  output logic                   o_cyc,
  input  logic                   i_ack,
  input  logic [31:0]            i_data,
  output logic                   o_valid,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_instr,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            LW       = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_TWO  = LW'(2);
  localparam bit            HAS_C    = (EXT_C != 0);

  // A halfword starts a 32-bit instruction when its low bits are 2'b11;
  // without compressed support every instruction is 32 bits.
  function automatic logic is_wide(input logic [15:0] half);
    return !HAS_C || (half[1:0] == 2'b11);
  endfunction

  // Redirect targets drop bit 0 always, and bit 1 too in 32-bit-only mode.
  function automatic logic [31:0] pc_align(input logic [31:0] t);
    return HAS_C ? {t[31:1], 1'b0} : {t[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Queue storage and pointers
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_nx;
  logic [LW-1:0] level;

  // Fetch side: bus address, address to resume at after a stale ack,
  // run gate (keeps o_cyc low until the first edge after reset),
  // request-held flag and stale-ack discard flag.
  logic [31:0]   fetch_addr;
  logic [31:0]   redir_addr;
  logic          run;
  logic          busy;
  logic          discard;
  logic          ack_take;
  logic          push;

  // Output side: PC of the next instruction and its decode
  logic [31:0]   op;
  logic [31:0]   head_w;
  logic [15:0]   next_lo;
  logic [15:0]   half;
  logic          hi_sel;
  logic          wide;
  logic          span;
  logic          have;
  logic          consume;
  logic          pop;
  logic [31:0]   op_step;

  assign o_addr  = fetch_addr;
  assign o_pc    = op;
  assign o_level = level;

  // Bus request: once issued the request is held (busy) until acknowledged;
  // a new one is only raised while the queue has room for its word.
  always_comb begin
    o_cyc    = run && (busy || (level < LVL_FULL));
    ack_take = o_cyc && i_ack;
    push     = ack_take && !discard && !i_pc_select;
  end

  // Instruction extraction from the head word (and the following word when
  // a 32-bit instruction starts in the upper halfword of the head).
  always_comb begin
    rd_ptr_nx = rd_ptr + AW'(1);
    head_w    = mem[rd_ptr];
    next_lo   = mem[rd_ptr_nx][15:0];
    hi_sel    = HAS_C && op[1];
    half      = hi_sel ? head_w[31:16] : head_w[15:0];
    wide      = is_wide(half);
    span      = wide && hi_sel;
    have      = span ? (level >= LVL_TWO) : (level >= LVL_ONE);
    o_valid   = have && !i_pc_select;
    o_instr   = '0;
    if (o_valid) begin
      if (!wide) begin
        o_instr = {16'h0000, half};
      end else if (span) begin
        o_instr = {next_lo, head_w[31:16]};
      end else begin
        o_instr = head_w;
      end
    end
    consume   = o_valid && i_ready;
    // The head word is retired once consumption reaches its upper boundary.
    pop       = consume && (hi_sel || wide);
    op_step   = wide ? 32'd4 : 32'd2;
  end

  // Fetch control: bus address advance, redirect handling and stale-ack discard.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run        <= 1'b0;
      busy       <= 1'b0;
      discard    <= 1'b0;
      fetch_addr <= word_align(RESET_ADDR);
    end else begin
      run  <= 1'b1;
      busy <= o_cyc && !i_ack;
      if (ack_take) begin
        discard <= 1'b0;
      end else if (i_pc_select && o_cyc) begin
        discard <= 1'b1;
      end
      if (ack_take) begin
        if (i_pc_select) begin
          fetch_addr <= word_align(i_pc_target);
        end else if (discard) begin
          fetch_addr <= redir_addr;
        end else begin
          fetch_addr <= fetch_addr + 32'd4;
        end
      end else if (i_pc_select && !o_cyc) begin
        fetch_addr <= word_align(i_pc_target);
      end
    end
  end

  // Queue bookkeeping and output PC; a redirect flushes and overrides both.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      op     <= RESET_ADDR;
    end else if (i_pc_select) begin
      level  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      op     <= pc_align(i_pc_target);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nx;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (consume) begin
        op <= op + op_step;
      end
    end
  end

  // Data storage: queue words and the pending redirect address (no reset needed).
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
    if (i_pc_select) begin
      redir_addr <= word_align(i_pc_target);
    end
  end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Bench for rv_fetch_queue: scripted cycle table, backpressure / async reset
// sequences and a randomized run against a byte-memory reference model.
module tb_rv_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic        i_pc_select;
  logic [31:0] i_pc_target;
  logic [31:0] o_addr;
  logic        o_cyc;
  logic        i_ack;
  logic [31:0] i_data;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;
  logic [2:0]  o_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_fetch_queue #(
    .RESET_ADDR (32'h0000_0000),
    .DEPTH      (DEPTH),
    .EXT_C      (1)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (i_reset_n),
    .i_pc_select (i_pc_select),
    .i_pc_target (i_pc_target),
    .o_addr      (o_addr),
    .o_cyc       (o_cyc),
    .i_ack       (i_ack),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .o_pc        (o_pc),
    .o_instr     (o_instr),
    .i_ready     (i_ready),
    .o_level     (o_level)
  );

  typedef struct {
    logic        sel;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        rdy;
    logic        e_cyc;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [2:0]  e_lvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic sel, input logic [31:0] tgt, input logic ack,
                              input logic [31:0] data, input logic rdy, input logic e_cyc,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [2:0] e_lvl);
    vec_t v;
    v.sel = sel; v.tgt = tgt; v.ack = ack; v.data = data; v.rdy = rdy;
    v.e_cyc = e_cyc; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_lvl = e_lvl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory image seen by the fetch bus: a fixed hash of the word address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] x;
    x = a ^ 32'h5bd1_e995;
    x = x * 32'h9e37_79b1;
    x = x ^ (x >> 15);
    x = x * 32'h85eb_ca6b;
    x = x ^ (x >> 13);
    return x;
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = memw({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] ref_len(input logic [31:0] pc);
    logic [15:0] h;
    h = hw(pc);
    return (h[1:0] == 2'b11) ? 32'd4 : 32'd2;
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    logic [15:0] h;
    h = hw(pc);
    return (h[1:0] == 2'b11) ? {hw(pc + 32'd2), h} : {16'h0000, h};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for a few cycles, check reset outputs, release between edges,
  // then step to the first cycle in which requests may be issued.
  task automatic do_reset(input logic stale_ack);
    i_reset_n   = 1'b0;
    i_pc_select = 1'b0;
    i_pc_target = 32'h0;
    i_ack       = stale_ack;
    i_data      = 32'hBAD0_BAD3;
    i_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc",   32'(o_cyc),   32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr,      32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_pc",    o_pc,         32'd0);
    chk("rst_addr",  o_addr,       32'd0);
    @(negedge clk);
    i_reset_n = 1'b1;
    #1;
    chk("post_rst_cyc_low", 32'(o_cyc), 32'd0);
    next_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] mpc;
    logic        pcyc;
    logic        pack;
    logic [31:0] paddr;
    int          delivered;

    // Scripted cycles: compressed mix, spanning instruction, redirects with a
    // stale outstanding request, and a redirect coinciding with an ack.
    tbl.push_back(mk(0, 32'h0,   1, 32'h4501_0001, 1, 1, 32'h000, 0, 32'h000, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   1, 32'h0000_0537, 1, 1, 32'h004, 1, 32'h000, 32'h0000_0001, 1));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         1, 1, 32'h008, 1, 32'h002, 32'h0000_4501, 2));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         0, 1, 32'h008, 1, 32'h004, 32'h0000_0537, 1));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         1, 1, 32'h008, 1, 32'h004, 32'h0000_0537, 1));
    tbl.push_back(mk(1, 32'h102, 0, 32'h0,         1, 1, 32'h008, 0, 32'h008, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   1, 32'hDEAD_BEEF, 1, 1, 32'h008, 0, 32'h102, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   1, 32'h0513_1234, 1, 1, 32'h100, 0, 32'h102, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   1, 32'h0000_0000, 1, 1, 32'h104, 0, 32'h102, 32'h0000_0000, 1));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         1, 1, 32'h108, 1, 32'h102, 32'h0000_0513, 2));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         0, 1, 32'h108, 1, 32'h106, 32'h0000_0000, 1));
    tbl.push_back(mk(1, 32'h200, 0, 32'h0,         0, 1, 32'h108, 0, 32'h106, 32'h0000_0000, 1));
    tbl.push_back(mk(0, 32'h0,   1, 32'hFFFF_FFFF, 0, 1, 32'h108, 0, 32'h200, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         1, 1, 32'h200, 0, 32'h200, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   1, 32'h0000_0013, 1, 1, 32'h200, 0, 32'h200, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         1, 1, 32'h204, 1, 32'h200, 32'h0000_0013, 1));
    tbl.push_back(mk(1, 32'h301, 1, 32'hAAAA_AAAA, 1, 1, 32'h204, 0, 32'h204, 32'h0000_0000, 0));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,         1, 1, 32'h300, 0, 32'h300, 32'h0000_0000, 0));

    do_reset(1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      i_pc_select = tbl[i].sel;
      i_pc_target = tbl[i].tgt;
      i_ack       = tbl[i].ack;
      i_data      = tbl[i].data;
      i_ready     = tbl[i].rdy;
      #1;
      checks++;
      if (o_cyc !== tbl[i].e_cyc || o_addr !== tbl[i].e_addr || o_valid !== tbl[i].e_valid ||
          o_pc !== tbl[i].e_pc || o_instr !== tbl[i].e_instr || o_level !== tbl[i].e_lvl) begin
        errors++;
        $display("FAIL vec%0d: got cyc=%b addr=%h valid=%b pc=%h instr=%h lvl=%0d expected cyc=%b addr=%h valid=%b pc=%h instr=%h lvl=%0d",
                 i, o_cyc, o_addr, o_valid, o_pc, o_instr, o_level,
                 tbl[i].e_cyc, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_lvl);
      end
      next_cycle();
    end

    // Backpressure: every request acked at once with NOPs, decode stalled.
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      i_ready = 1'b0;
      i_ack   = o_cyc;
      i_data  = NOP;
      #1;
      if (o_level == 3'(DEPTH)) chk("bp_cyc_drop", 32'(o_cyc), 32'd0);
      if (o_valid) begin
        chk("bp_hold_pc", o_pc, 32'd0);
        chk("bp_hold_instr", o_instr, NOP);
      end
      if (c == 9) begin
        chk("bp_full_level", 32'(o_level), 32'(DEPTH));
        chk("bp_valid", 32'(o_valid), 32'd1);
      end
      next_cycle();
    end
    exp_pc = 32'd0;
    for (int c = 0; c < 16; c++) begin
      i_ready = 1'b1;
      i_ack   = o_cyc;
      i_data  = NOP;
      #1;
      chk("line_valid", 32'(o_valid), 32'd1);
      chk("line_pc", o_pc, exp_pc);
      chk("line_instr", o_instr, NOP);
      chk("line_level_max", 32'(o_level <= 3'(DEPTH)), 32'd1);
      exp_pc = exp_pc + 32'd4;
      next_cycle();
    end

    // Asynchronous reset dropped between clock edges mid-stream.
    i_ready = 1'b1;
    i_ack   = o_cyc;
    i_data  = NOP;
    #1;
    chk("pre_arst_cyc", 32'(o_cyc), 32'd1);
    chk("pre_arst_valid", 32'(o_valid), 32'd1);
    #1;
    i_reset_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(o_cyc), 32'd0);
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_pc", o_pc, 32'd0);
    chk("arst_level", 32'(o_level), 32'd0);
    chk("arst_instr", o_instr, 32'd0);

    // Randomized traffic against the byte-memory model; a stale ack is held
    // across reset release to be sure it is ignored.
    do_reset(1'b1);
    mpc       = 32'd0;
    pcyc      = 1'b0;
    pack      = 1'b0;
    paddr     = 32'd0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      i_pc_select = ($urandom_range(0, 99) < 4);
      i_pc_target = 32'($urandom_range(0, 1023));
      i_ack       = o_cyc && ($urandom_range(0, 99) < 60);
      i_data      = i_ack ? memw(o_addr) : $urandom;
      i_ready     = ($urandom_range(0, 99) < 70);
      #1;
      if (pcyc && !pack) begin
        chk("hold_cyc", 32'(o_cyc), 32'd1);
        chk("hold_addr", o_addr, paddr);
      end
      chk("addr_align", 32'(o_addr[1:0]), 32'd0);
      chk("level_max", 32'(o_level <= 3'(DEPTH)), 32'd1);
      if (!o_valid) chk("idle_instr", o_instr, 32'd0);
      if (i_pc_select) chk("redir_valid", 32'(o_valid), 32'd0);
      if (o_valid && i_ready) begin
        chk("rand_pc", o_pc, mpc);
        chk("rand_instr", o_instr, ref_instr(mpc));
        mpc = mpc + ref_len(mpc);
        delivered++;
      end
      if (i_pc_select) mpc = i_pc_target & ~32'd1;
      pcyc  = o_cyc;
      pack  = i_ack;
      paddr = o_addr;
      next_cycle();
    end
    chk("rand_progress", 32'(delivered > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_fetch_queue.md
RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000: PC after reset.
REQ-002 Parameter DEPTH, default 4: prefetch queue depth in 32-bit words; legal values are powers of 2, 2..16.
REQ-003 Parameter EXT_C, default 1: 1 enables 16-bit (compressed) instruction support; 0 gives 32-bit-only operation.
REQ-004 i_clk  in  1: the only clock; all state updates on its rising edge.
REQ-005 i_reset_n  in  1: reset, asynchronous, active-low.
REQ-006 i_pc_select  in  1: redirect request.
REQ-007 i_pc_target  in  32: redirect target PC.
REQ-008 o_addr  out  32: fetch bus address, always word-aligned (bits[1:0]=0).
REQ-009 o_cyc  out  1: fetch bus request.
REQ-010 i_ack  in  1: fetch bus acknowledge; i_data is valid in the same cycle.
REQ-011 i_data  in  32: fetched word.
REQ-012 o_valid  out  1: o_pc and o_instr are valid.
REQ-013 o_pc  out  32: PC of the presented instruction.
REQ-014 o_instr  out  32: presented instruction; a 16-bit instruction is placed in [15:0] with [31:16]=0.
REQ-015 i_ready  in  1: decode accepts the instruction.
REQ-016 o_level  out  $clog2(DEPTH)+1: number of words in the queue.

Function
REQ-017 Request rule: o_cyc=1 when not in reset and (level + outstanding) < DEPTH; at most one request is outstanding.
REQ-018 Bus hold: once o_cyc=1, o_cyc and o_addr stay stable until the cycle i_ack=1.
REQ-019 Ack without redirect: i_data is pushed to the queue tail and o_addr advances by 4.
REQ-020 Issue timing: a new request may be issued in the cycle after an ack.
REQ-021 Push-to-output latency: a word acked in cycle N is visible to the output logic in cycle N+1.
REQ-022 Output PC: the output PC register op tracks the next instruction to deliver. o_pc=op. The head halfword is selected by op[1].
REQ-023 Instruction length (EXT_C=1): a halfword with [1:0]=2'b11 is a 32-bit instruction; any other value is a 16-bit instruction.
REQ-024 Instruction length (EXT_C=0): every instruction is 32 bits, and op[1] is forced to 0.
REQ-025 o_valid=1 when the queue holds enough data for the instruction at op: one word for a 16-bit instruction; one word for a 32-bit instruction with op[1]=0; two words for a 32-bit instruction with op[1]=1 (spanning instruction = {next word[15:0], head[31:16]}).
REQ-026 Handshake: an instruction is consumed only when o_valid & i_ready.
REQ-027 On consume, op advances by 2 for a 16-bit instruction or by 4 for a 32-bit instruction. The head word is popped when the consumed bytes reach or cross its upper word boundary.
REQ-028 Stall: when o_valid=1 and i_ready=0, o_pc and o_instr hold stable.
REQ-029 Push and pop in the same cycle are both performed; level is unchanged for push+1 pop.
REQ-030 Invalid output: when o_valid=0, o_instr=0.
REQ-031 Redirect cycle (i_pc_select=1):
- the queue is flushed and o_valid is forced to 0;
- op <= i_pc_target, with bit0 ignored, and bit1 also ignored when EXT_C=0;
- the fetch address <= {i_pc_target[31:2],2'b00}.
REQ-032 Redirect with a request outstanding and no ack in that cycle: the request completes at its original address, its ack data is discarded, and the next request uses the redirected address.
REQ-033 Redirect with i_ack in the same cycle: the acked data is discarded.
REQ-034 Back-to-back redirects: the last redirect wins, and at most one stale ack is discarded.
REQ-035 Redirect has priority over consume and push in the same cycle.

Reset
REQ-036 While i_reset_n=0: o_cyc=0, o_valid=0, o_instr=0, o_level=0, o_pc=RESET_ADDR, o_addr={RESET_ADDR[31:2],2'b00}; the queue is empty and the discard flag is clear.
REQ-037 Reset asserted mid-transaction abandons the outstanding request, and any later ack is ignored until the first post-reset request.
REQ-038 o_cyc may first assert in the cycle after reset deassertion.

Verification
REQ-039 Straight line: RESET_ADDR=0, ack every request with 32-bit NOPs (32'h00000013), i_ready=1 -> o_pc sequence 0,4,8,...; o_level never exceeds DEPTH.
REQ-040 Backpressure: i_ready=0 for 10 cycles, DEPTH=4 -> o_cyc drops once o_level=4; o_pc and o_instr are held; 1 instruction is consumed per cycle after i_ready is released.
REQ-041 Compressed mix (EXT_C=1): words 32'h4501_0001 then 32'h0000_0537 are acked from address 0 -> o_pc/o_instr sequence 0/32'h0000_0001, 2/32'h0000_4501, 4/32'h0000_0537.
REQ-042 Spanning instruction: redirect to 0x102 with word@0x100 = 32'h0513_xxxx and word@0x104 = 32'h0000_0000 -> o_valid only after both words, o_instr=32'h0000_0513, o_pc=0x102, next o_pc=0x106.
REQ-043 Redirect during outstanding request: redirect to 0x200 while o_addr=0x10 is unacked -> o_addr stays 0x10 until the ack, that ack's data never appears on o_instr, then o_addr=0x200.
REQ-044 Async reset mid-stream: i_reset_n low between clock edges -> o_cyc and o_valid fall immediately, o_pc=RESET_ADDR, o_level=0.
